// File: rtl/tiger_arb_pkg.sv
`default_nettype none
// ============================================================================
// tiger_arb_pkg : shared types for the tiger Avalon arbiter
// Revision      : 1.0
// ============================================================================
package tiger_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_IM = 2'd1,
    ST_OWN_DM = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t ID_IM = 1'b0;
  localparam req_id_t ID_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tiger_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// tiger_arb_tag_fifo : requester-ID FIFO tracking outstanding reads
// Revision           : 1.0
// ============================================================================
module tiger_arb_tag_fifo
  import tiger_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  req_id_t                push_id,
  input  logic                   pop,
  output req_id_t                head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tiger_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// tiger_avalon_arbiter : instruction/data requester arbiter onto one Avalon
//                        master. Define TIGER_ARB_ROUND_ROBIN_EN for
//                        round-robin conflicts, else data has fixed priority.
// Revision             : 1.0
// ============================================================================
module tiger_avalon_arbiter
  import tiger_arb_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int RESET_GRANT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] im_address,
  input  logic        im_read,
  output logic [31:0] im_readdata,
  output logic        im_waitrequest,
  output logic        im_readdatavalid,
  input  logic [31:0] dm_address,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_writedata,
  input  logic [3:0]  dm_byteenable,
  output logic [31:0] dm_readdata,
  output logic        dm_waitrequest,
  output logic        dm_readdatavalid,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid
);

  localparam int          CW       = $clog2(MAX_PENDING);
  localparam logic [CW:0] CNT_MAX  = (CW + 1)'(MAX_PENDING);
  localparam req_id_t     RST_ID   = (RESET_GRANT != 0) ? ID_DM : ID_IM;

  arb_state_e  state_q, state_d;
  req_id_t     last_grant_q, last_grant_d;
  logic        err_q, err_d;

  logic        own_im, own_dm;
  logic        im_cmd, dm_rd_ok, dm_cmd;
  logic        cmd_valid, accept, push, pop, win_dm;
  req_id_t     head_id;
  logic        fifo_full, fifo_empty;
  logic [CW:0] fifo_count;

  tiger_arb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (own_dm ? ID_DM : ID_IM),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Ownership is masked by reset so outputs sit at idle values from the first cycle.
  assign own_im   = !reset && (state_q == ST_OWN_IM);
  assign own_dm   = !reset && (state_q == ST_OWN_DM);
  assign im_cmd   = im_read && !fifo_full;
  assign dm_rd_ok = dm_read && !dm_write && !fifo_full;
  assign dm_cmd   = dm_write || dm_rd_ok;

  assign cmd_valid = (own_im && im_cmd) || (own_dm && dm_cmd);
  assign accept    = cmd_valid && !m_waitrequest;
  assign push      = accept && m_read;
  assign pop       = !reset && m_readdatavalid && !fifo_empty;

  assign m_read       = (own_im && im_cmd) || (own_dm && dm_rd_ok);
  assign m_write      = own_dm && dm_write;
  assign m_address    = own_im ? im_address : (own_dm ? dm_address : 32'h0);
  assign m_writedata  = own_dm ? dm_writedata : 32'h0;
  assign m_byteenable = own_im ? 4'hF : (own_dm ? dm_byteenable : 4'h0);

  assign im_waitrequest = !(own_im && im_cmd && !m_waitrequest);
  assign dm_waitrequest = !(own_dm && dm_cmd && !m_waitrequest);

  assign im_readdata      = m_readdata;
  assign dm_readdata      = m_readdata;
  assign im_readdatavalid = pop && (head_id == ID_IM);
  assign dm_readdatavalid = pop && (head_id == ID_DM);

`ifdef TIGER_ARB_ROUND_ROBIN_EN
  assign win_dm = (last_grant_q == ID_IM);
`else
  assign win_dm = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_d        = err_q || (m_readdatavalid && fifo_empty);
    case (state_q)
      ST_IDLE: begin
        if (im_read && (dm_read || dm_write)) begin
          state_d      = win_dm ? ST_OWN_DM : ST_OWN_IM;
          last_grant_d = win_dm ? ID_DM : ID_IM;
        end else if (im_read) begin
          state_d      = ST_OWN_IM;
          last_grant_d = ID_IM;
        end else if (dm_read || dm_write) begin
          state_d      = ST_OWN_DM;
          last_grant_d = ID_DM;
        end
      end
      // Stay only while a command is held stalled by the slave.
      ST_OWN_IM, ST_OWN_DM: begin
        if (!cmd_valid || accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= RST_ID;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    (fifo_count <= CNT_MAX));

endmodule
`default_nettype wire

// File: tb/tb_tiger_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tiger_avalon_arbiter : directed self-checking bench for the arbiter
// Revision                : 1.0
// ============================================================================
module tb_tiger_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_address, im_readdata;
  logic        im_read, im_waitrequest, im_readdatavalid;
  logic [31:0] dm_address, dm_writedata, dm_readdata;
  logic        dm_read, dm_write, dm_waitrequest, dm_readdatavalid;
  logic [3:0]  dm_byteenable;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [3:0]  m_byteenable;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tiger_avalon_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .im_address       (im_address),
    .im_read          (im_read),
    .im_readdata      (im_readdata),
    .im_waitrequest   (im_waitrequest),
    .im_readdatavalid (im_readdatavalid),
    .dm_address       (dm_address),
    .dm_read          (dm_read),
    .dm_write         (dm_write),
    .dm_writedata     (dm_writedata),
    .dm_byteenable    (dm_byteenable),
    .dm_readdata      (dm_readdata),
    .dm_waitrequest   (dm_waitrequest),
    .dm_readdatavalid (dm_readdatavalid),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_writedata      (m_writedata),
    .m_byteenable     (m_byteenable),
    .m_readdata       (m_readdata),
    .m_waitrequest    (m_waitrequest),
    .m_readdatavalid  (m_readdatavalid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    im_address      = '0;
    im_read         = 1'b0;
    dm_address      = '0;
    dm_read         = 1'b0;
    dm_write        = 1'b0;
    dm_writedata    = '0;
    dm_byteenable   = '0;
    m_readdata      = '0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    idle_inputs();
    im_read         = 1'b1;
    dm_write        = 1'b1;
    dm_address      = 32'hFFFF_0000;
    dm_writedata    = 32'h5555_AAAA;
    dm_byteenable   = 4'hF;
    m_readdatavalid = 1'b1;
    step();
    step();
    #1;
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rst_m_read: got %b want 0", m_read); end
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL rst_m_write: got %b want 0", m_write); end
    n_checks++; if (m_address !== 32'h0) begin n_fail++; $display("FAIL rst_m_address: got %h want 0", m_address); end
    n_checks++; if (m_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_m_writedata: got %h want 0", m_writedata); end
    n_checks++; if (m_byteenable !== 4'h0) begin n_fail++; $display("FAIL rst_m_byteenable: got %h want 0", m_byteenable); end
    n_checks++; if (im_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_im_wait: got %b want 1", im_waitrequest); end
    n_checks++; if (dm_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_dm_wait: got %b want 1", dm_waitrequest); end
    n_checks++; if (im_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_im_rdv: got %b want 0", im_readdatavalid); end
    n_checks++; if (dm_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_dm_rdv: got %b want 0", dm_readdatavalid); end
    n_checks++; if (dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", dut.u_fifo.count_q); end
    n_checks++; if (dut.last_grant_q !== 1'b1) begin n_fail++; $display("FAIL rst_last_grant: got %b want 1", dut.last_grant_q); end
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_im_read();
    im_address = 32'h0000_0100;
    im_read    = 1'b1;
    #1;
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL im_idle_m_read: got %b want 0", m_read); end
    n_checks++; if (im_waitrequest !== 1'b1) begin n_fail++; $display("FAIL im_idle_wait: got %b want 1", im_waitrequest); end
    step();
    n_checks++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL im_m_read: got %b want 1", m_read); end
    n_checks++; if (m_address !== 32'h0000_0100) begin n_fail++; $display("FAIL im_m_address: got %h want 00000100", m_address); end
    n_checks++; if (m_byteenable !== 4'hF) begin n_fail++; $display("FAIL im_m_byteenable: got %h want f", m_byteenable); end
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL im_m_write: got %b want 0", m_write); end
    n_checks++; if (m_writedata !== 32'h0) begin n_fail++; $display("FAIL im_m_writedata: got %h want 0", m_writedata); end
    n_checks++; if (im_waitrequest !== 1'b0) begin n_fail++; $display("FAIL im_grant_wait: got %b want 0", im_waitrequest); end
    step();
    im_read = 1'b0;
    #1;
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL im_single_read: got %b want 0", m_read); end
    step();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h1234_5678;
    #1;
    n_checks++; if (im_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL im_rdv: got %b want 1", im_readdatavalid); end
    n_checks++; if (im_readdata !== 32'h1234_5678) begin n_fail++; $display("FAIL im_readdata: got %h want 12345678", im_readdata); end
    n_checks++; if (dm_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL im_dm_rdv: got %b want 0", dm_readdatavalid); end
    step();
    m_readdatavalid = 1'b0;
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL im_count_after: got %0d want 0", dut.u_fifo.count_q); end
  endtask

  task automatic test_conflict();
    logic first_dm;
`ifdef TIGER_ARB_ROUND_ROBIN_EN
    first_dm = 1'b0;
`else
    first_dm = 1'b1;
`endif
    do_reset();
    im_address = 32'h0000_00A0;
    dm_address = 32'h0000_00B0;
    im_read    = 1'b1;
    dm_read    = 1'b1;
    step();
    n_checks++; if (m_address !== (first_dm ? 32'h0000_00B0 : 32'h0000_00A0)) begin n_fail++; $display("FAIL cf_first_addr: got %h want %h", m_address, first_dm ? 32'h0000_00B0 : 32'h0000_00A0); end
    n_checks++; if (m_read !== 1'b1) begin n_fail++; $display("FAIL cf_first_read: got %b want 1", m_read); end
    n_checks++; if (im_waitrequest !== first_dm) begin n_fail++; $display("FAIL cf_first_im_wait: got %b want %b", im_waitrequest, first_dm); end
    n_checks++; if (dm_waitrequest !== !first_dm) begin n_fail++; $display("FAIL cf_first_dm_wait: got %b want %b", dm_waitrequest, !first_dm); end
    step();
    if (first_dm) dm_read = 1'b0; else im_read = 1'b0;
    #1;
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL cf_gap_read: got %b want 0", m_read); end
    step();
    n_checks++; if (m_address !== (first_dm ? 32'h0000_00A0 : 32'h0000_00B0)) begin n_fail++; $display("FAIL cf_second_addr: got %h want %h", m_address, first_dm ? 32'h0000_00A0 : 32'h0000_00B0); end
    n_checks++; if ((first_dm ? im_waitrequest : dm_waitrequest) !== 1'b0) begin n_fail++; $display("FAIL cf_second_wait: got %b want 0", first_dm ? im_waitrequest : dm_waitrequest); end
    step();
    im_read = 1'b0;
    dm_read = 1'b0;
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd2) begin n_fail++; $display("FAIL cf_count: got %0d want 2", dut.u_fifo.count_q); end
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h1111_1111;
    #1;
    n_checks++; if (dm_readdatavalid !== first_dm) begin n_fail++; $display("FAIL cf_ret1_dm: got %b want %b", dm_readdatavalid, first_dm); end
    n_checks++; if (im_readdatavalid !== !first_dm) begin n_fail++; $display("FAIL cf_ret1_im: got %b want %b", im_readdatavalid, !first_dm); end
    n_checks++; if (dm_readdata !== 32'h1111_1111) begin n_fail++; $display("FAIL cf_ret1_data: got %h want 11111111", dm_readdata); end
    step();
    m_readdata = 32'h2222_2222;
    #1;
    n_checks++; if (dm_readdatavalid !== !first_dm) begin n_fail++; $display("FAIL cf_ret2_dm: got %b want %b", dm_readdatavalid, !first_dm); end
    n_checks++; if (im_readdatavalid !== first_dm) begin n_fail++; $display("FAIL cf_ret2_im: got %b want %b", im_readdatavalid, first_dm); end
    n_checks++; if (im_readdata !== 32'h2222_2222) begin n_fail++; $display("FAIL cf_ret2_data: got %h want 22222222", im_readdata); end
    step();
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_write_stall();
    dm_address    = 32'h0000_0200;
    dm_writedata  = 32'hDEAD_BEEF;
    dm_byteenable = 4'h3;
    dm_write      = 1'b1;
    m_waitrequest = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_waitrequest = 1'b0;
      #1;
      n_checks++; if (m_write !== 1'b1) begin n_fail++; $display("FAIL wr_m_write[%0d]: got %b want 1", i, m_write); end
      n_checks++; if (m_address !== 32'h0000_0200) begin n_fail++; $display("FAIL wr_m_address[%0d]: got %h want 00000200", i, m_address); end
      n_checks++; if (m_writedata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_m_writedata[%0d]: got %h want deadbeef", i, m_writedata); end
      n_checks++; if (m_byteenable !== 4'h3) begin n_fail++; $display("FAIL wr_m_byteenable[%0d]: got %h want 3", i, m_byteenable); end
      n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL wr_m_read[%0d]: got %b want 0", i, m_read); end
      n_checks++; if (dm_waitrequest !== (i < 3)) begin n_fail++; $display("FAIL wr_dm_wait[%0d]: got %b want %b", i, dm_waitrequest, (i < 3)); end
      step();
    end
    dm_write = 1'b0;
    #1;
    n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL wr_single: got %b want 0", m_write); end
    n_checks++; if (dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL wr_no_tag: got %0d want 0", dut.u_fifo.count_q); end
  endtask

  task automatic test_fifo_full();
    int  acc;
    logic got;
    do_reset();
    acc        = 0;
    got        = 1'b0;
    im_address = 32'h0000_0300;
    im_read    = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (m_read && !im_waitrequest) acc++;
      step();
    end
    #1;
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL full_accepts: got %0d want 4", acc); end
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL full_m_read: got %b want 0", m_read); end
    n_checks++; if (im_waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_wait: got %b want 1", im_waitrequest); end
    n_checks++; if (dut.u_fifo.count_q !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", dut.u_fifo.count_q); end
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hCAFE_0001;
    #1;
    n_checks++; if (im_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL full_pop_rdv: got %b want 1", im_readdatavalid); end
    step();
    m_readdatavalid = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (m_read && !im_waitrequest) got = 1'b1;
      step();
    end
    im_read = 1'b0;
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL full_fifth_issue: got %b want 1", got); end
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", dut.u_fifo.count_q); end
    for (int k = 0; k < 4; k++) begin
      m_readdatavalid = 1'b1;
      #1;
      n_checks++; if (im_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL full_drain[%0d]: got %b want 1", k, im_readdatavalid); end
      step();
    end
    m_readdatavalid = 1'b0;
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", dut.u_fifo.count_q); end
  endtask

  task automatic test_reset_mid();
    int acc;
    do_reset();
    acc        = 0;
    dm_address = 32'h0000_0400;
    dm_read    = 1'b1;
    for (int k = 0; k < 8 && acc < 2; k++) begin
      #1;
      if (m_read && !dm_waitrequest) acc++;
      step();
    end
    dm_read = 1'b0;
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd2) begin n_fail++; $display("FAIL rm_outstanding: got %0d want 2", dut.u_fifo.count_q); end
    reset = 1'b1;
    step();
    m_readdatavalid = 1'b1;
    #1;
    n_checks++; if (dm_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rm_in_rst_dm_rdv: got %b want 0", dm_readdatavalid); end
    n_checks++; if (dm_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rm_in_rst_wait: got %b want 1", dm_waitrequest); end
    step();
    reset           = 1'b0;
    m_readdatavalid = 1'b0;
    #1;
    n_checks++; if (dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL rm_flushed: got %0d want 0", dut.u_fifo.count_q); end
    n_checks++; if (dut.err_q !== 1'b0) begin n_fail++; $display("FAIL rm_err_clear: got %b want 0", dut.err_q); end
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hBAD0_0BAD;
    #1;
    n_checks++; if (dm_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rm_stray_dm_rdv: got %b want 0", dm_readdatavalid); end
    n_checks++; if (im_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rm_stray_im_rdv: got %b want 0", im_readdatavalid); end
    step();
    m_readdatavalid = 1'b0;
    #1;
    n_checks++; if (dut.err_q !== 1'b1) begin n_fail++; $display("FAIL rm_err_set: got %b want 1", dut.err_q); end
    n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("FAIL rm_m_read: got %b want 0", m_read); end
    n_checks++; if (m_address !== 32'h0) begin n_fail++; $display("FAIL rm_m_address: got %h want 0", m_address); end
    n_checks++; if (dm_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rm_dm_wait: got %b want 1", dm_waitrequest); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_im_read();
    test_conflict();
    test_write_stall();
    test_fifo_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
